// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the five-stage ARM pipeline.
// Performs LDR/STR to an internal word-addressed data memory with a fixed
// wait-state latency and stalls upstream stages through freeze while busy.
// Optional feature macro: MEM_ADDR_CHECK_EN (out-of-range detection; when
// undefined the word index wraps modulo DEPTH and addr_err stays 0).
module mem_access_stage #(
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 4,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic        wb_en_in,
   input  logic [3:0]  dest_in,
   input  logic [31:0] alu_res,
   input  logic [31:0] val_rm,
   output logic        wb_en_out,
   output logic [3:0]  dest_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] mem_result,
   output logic        ready,
   output logic        freeze,
   output logic        addr_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_reg;
   logic [3:0]    cnt_reg;
   logic [31:0]   mem [DEPTH];

   logic          req;
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic          in_range;
   logic          finish;
   logic          do_write;

   assign req    = mem_r_en | mem_w_en;
   assign offset = alu_res - BASE_ADDR;
   // Low byte-lane bits are dropped; the low AW word bits select the entry.
   assign idx    = AW'(offset >> 2);

`ifdef MEM_ADDR_CHECK_EN
   assign in_range = (alu_res >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH));
`else
   assign in_range = 1'b1;
`endif

   // Last BUSY cycle: the access commits on the edge that ends it.
   assign finish   = (state_reg == BUSY) && (cnt_reg == 4'(WAIT_CYCLES));
   // Reset wins over a pending write, so an aborted store never lands.
   assign do_write = finish && mem_w_en && in_range && !rst;

   // Instruction sideband passes straight through with no delay.
   assign wb_en_out   = wb_en_in;
   assign dest_out    = dest_in;
   assign alu_res_out = alu_res;

   // The stage may release its instruction when idle with no request or
   // in the DONE cycle; otherwise everything upstream is stalled.
   assign ready  = (state_reg == DONE) || ((state_reg == IDLE) && !req);
   assign freeze = ~ready;

   // Data memory write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[idx] <= val_rm;
      end
   end

   // Access sequencer: IDLE -> BUSY (WAIT_CYCLES cycles) -> DONE -> IDLE,
   // with load data and the address flag registered on the BUSY->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         mem_result <= 32'd0;
         addr_err   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               addr_err <= 1'b0;
               if (req) begin
                  state_reg <= BUSY;
                  cnt_reg   <= 4'd1;
               end
            end
            BUSY: begin
               if (finish) begin
                  state_reg <= DONE;
                  cnt_reg   <= 4'd0;
                  addr_err  <= ~in_range;
                  if (mem_w_en) begin
                     // A combined read+write request is a store that
                     // reports zero as its load data.
                     if (mem_r_en) begin
                        mem_result <= 32'd0;
                     end
                  end else begin
                     mem_result <= in_range ? mem[idx] : 32'd0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            DONE: begin
               // Pipeline advances on this edge, so no re-issue check.
               state_reg <= IDLE;
               addr_err  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= 4'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed steps with a scoreboard queue of
// expected completions (freeze length, load data, address flag, sideband).
module tb_mem_access_stage;
   localparam int          W     = 4;
   localparam int          DEP   = 64;
   localparam logic [31:0] BASE  = 32'd1024;
`ifdef MEM_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en, wb_en_in;
   logic [3:0]  dest_in;
   logic [31:0] alu_res, val_rm;
   logic        wb_en_out;
   logic [3:0]  dest_out;
   logic [31:0] alu_res_out, mem_result;
   logic        ready, freeze, addr_err;

   always #5 clk = ~clk;

   mem_access_stage #(.DEPTH(DEP), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .wb_en_in(wb_en_in), .dest_in(dest_in),
      .alu_res(alu_res), .val_rm(val_rm),
      .wb_en_out(wb_en_out), .dest_out(dest_out),
      .alu_res_out(alu_res_out), .mem_result(mem_result),
      .ready(ready), .freeze(freeze), .addr_err(addr_err)
   );

   typedef struct {
      string       tag;
      int          freeze_len;
      bit          chk_res;
      logic [31:0] res;
      logic        err;
      logic [31:0] alu;
      logic [3:0]  dest;
      logic        wb;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] ref_mem [DEP];
   bit          known [DEP];
   logic [31:0] model_res;
   bit          res_known;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_in_range(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEP));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'(((a - BASE) >> 2) & 32'(DEP - 1));
   endfunction

   // Predict, push, drive one instruction, then wait for the stage to release it.
   task automatic issue(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      bit   bad;
      int   ix;
      bad = CHECK_EN && !m_in_range(a);
      ix  = m_idx(a);
      e.tag        = tag;
      e.alu        = a;
      e.dest       = 4'($urandom_range(0, 15));
      e.wb         = 1'($urandom_range(0, 1));
      e.freeze_len = (r | w) ? W + 1 : 0;
      e.err        = (r | w) && bad;
      if (w) begin
         if (!bad) begin
            ref_mem[ix] = d;
            known[ix]   = 1'b1;
         end
         if (r) begin
            model_res = 32'd0;
            res_known = 1'b1;
         end
      end else if (r) begin
         if (bad) begin
            model_res = 32'd0;
            res_known = 1'b1;
         end else begin
            model_res = ref_mem[ix];
            res_known = known[ix];
         end
      end
      e.chk_res = res_known;
      e.res     = model_res;
      sb.push_back(e);

      @(posedge clk); #1;
      mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
      dest_in = e.dest; wb_en_in = e.wb;

      n = 0;
      forever begin
         @(negedge clk);
         check({tag, " freeze==~ready"}, {31'd0, freeze}, {31'd0, ~ready});
         if (ready) break;
         n++;
         if (n > 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: ready observed 0 required 1", tag);
            break;
         end
      end

      e = sb.pop_front();
      check({e.tag, " freeze_len"}, 32'(n), 32'(e.freeze_len));
      check({e.tag, " alu_res_out"}, alu_res_out, e.alu);
      check({e.tag, " dest_out"}, {28'd0, dest_out}, {28'd0, e.dest});
      check({e.tag, " wb_en_out"}, {31'd0, wb_en_out}, {31'd0, e.wb});
      check({e.tag, " addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
      if (e.chk_res) check({e.tag, " mem_result"}, mem_result, e.res);
      $display("txn %-12s r=%0b w=%0b addr=%0d data=%h freeze=%0d result=%h err=%0b",
               e.tag, r, w, a, d, n, mem_result, addr_err);
   endtask

   initial begin
      rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0;
      dest_in = 4'd0; alu_res = 32'd0; val_rm = 32'd0;
      model_res = 32'd0; res_known = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset ready", {31'd0, ready}, 32'd1);
      check("reset freeze", {31'd0, freeze}, 32'd0);
      check("reset mem_result", mem_result, 32'd0);
      check("reset addr_err", {31'd0, addr_err}, 32'd0);

      // Non-memory instructions: zero-latency pass-through
      issue("alu5", 1'b0, 1'b0, 32'h5, 32'h0);
      issue("alu_a", 1'b0, 1'b0, 32'hCAFE0001, 32'h1);
      issue("alu_b", 1'b0, 1'b0, 32'h0, 32'h2);

      // Store then load, back to back
      issue("str1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      issue("ldr1028", 1'b1, 1'b0, 32'd1028, 32'h0);
      issue("str1032", 1'b0, 1'b1, 32'd1032, 32'd7);
      issue("ldr1032", 1'b1, 1'b0, 32'd1032, 32'h0);
      issue("alu_c", 1'b0, 1'b0, 32'h77, 32'h0);

      // Reset during the 3rd BUSY cycle of a store aborts it
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b1; alu_res = 32'd1040; val_rm = 32'h1234;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; mem_w_en = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      model_res = 32'd0; res_known = 1'b1;
      @(negedge clk);
      check("abort freeze", {31'd0, freeze}, 32'd0);
      check("abort ready", {31'd0, ready}, 32'd1);
      check("abort mem_result", mem_result, 32'd0);
      issue("ldr1040", 1'b1, 1'b0, 32'd1040, 32'h0);
      n_cmp++;
      assert (mem_result !== 32'h1234) else begin
         n_fail++;
         $error("FAIL abort_write: observed %h required not 00001234", mem_result);
      end

      // Combined request behaves as a store returning zero
      issue("both1044", 1'b1, 1'b1, 32'd1044, 32'd9);
      issue("ldr1044", 1'b1, 1'b0, 32'd1044, 32'h0);

      // Address range: 1280 maps past DEPTH (wraps to word 0 unless checked)
      issue("str1024", 1'b0, 1'b1, 32'd1024, 32'h0000A5A5);
      issue("str1280", 1'b0, 1'b1, 32'd1280, 32'h000000FF);
      issue("ldr1024", 1'b1, 1'b0, 32'd1024, 32'h0);
      issue("ldr1280", 1'b1, 1'b0, 32'd1280, 32'h0);
      issue("ldr1020", 1'b1, 1'b0, 32'd1020, 32'h0);
      issue("alu_d", 1'b0, 1'b0, 32'h9, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage ARM pipeline, placed between the EXE/MEM pipeline register and the MEM/WB pipeline register. It performs LDR/STR accesses to an internal word-addressed data memory with a fixed, parameterised wait-state latency. While an access is in flight it raises `freeze` to stall every upstream stage. Non-memory instructions pass straight through with no stall.

## Interface
Parameters:
- `DEPTH`, 64: data-memory depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 4: wait states per access; legal range 1–15.
- `BASE_ADDR`, 32'd1024: byte address that maps to word 0.

Ports:
- `clk`  in  1  single pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_r_en`  in  1  load request from the EXE/MEM register.
- `mem_w_en`  in  1  store request from the EXE/MEM register.
- `wb_en_in`  in  1  write-back enable, forwarded unchanged.
- `dest_in`  in  4  destination register, forwarded unchanged.
- `alu_res`  in  32  effective byte address, or the ALU result for non-memory instructions.
- `val_rm`  in  32  store data.
- `wb_en_out`  out  1  equals `wb_en_in`.
- `dest_out`  out  4  equals `dest_in`.
- `alu_res_out`  out  32  equals `alu_res`.
- `mem_result`  out  32  registered load data.
- `ready`  out  1  high when the current instruction may leave this stage.
- `freeze`  out  1  stall request to IF, ID, EXE and the pipeline registers; equals `~ready`.
- `addr_err`  out  1  out-of-range access flag; see Configuration.

## Operation
- Request: `req = mem_r_en | mem_w_en`. If both are set, the access is a store and `mem_result` is loaded with 0.
- Word index: `(alu_res - BASE_ADDR) >> 2`. Bits [1:0] are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `req`=0: `ready`=1; stay in IDLE.
  - IDLE, `req`=1: `ready`=0; on the next edge go to BUSY with `cnt`=1.
  - BUSY: `ready`=0. If `cnt==WAIT_CYCLES`, go to DONE on the next edge; otherwise increment `cnt`.
  - On the BUSY→DONE edge, a store writes `val_rm` to memory, or a load captures the addressed word into `mem_result`.
  - DONE: `ready`=1. Always return to IDLE on the next edge. The pipeline advances on that same edge, so the request is not re-issued.
- `mem_result` holds its value until the next load or store completes. Non-memory instructions do not change it.
- `cnt` is 4 bits wide and never exceeds `WAIT_CYCLES`.

## Timing
- Non-memory instruction: zero-latency pass-through; `ready`=1 in the same cycle.
- Memory instruction: `freeze` is high for exactly WAIT_CYCLES+1 cycles (the IDLE cycle plus WAIT_CYCLES BUSY cycles).
- Total occupancy of this stage for a memory instruction is WAIT_CYCLES+2 cycles.
- Load data is valid in DONE and is sampled by the MEM/WB register at the end of DONE.
- Back-to-back memory instructions: the next access starts in the IDLE cycle that follows DONE, with no bubble.
- Reset values: state IDLE, `cnt`=0, `mem_result`=0, `addr_err`=0, `ready`=1, `freeze`=0.
- Memory contents are not cleared by reset.
- `rst` asserted during BUSY: return to IDLE, abort the pending write, and leave `mem_result` at 0.
- `rst` has priority over every other event.

## Configuration
- `MEM_ADDR_CHECK_EN` defined:
  - A word index ≥ DEPTH, or `alu_res < BASE_ADDR`, sets `addr_err`=1 during DONE only.
  - Such a store is suppressed; such a load returns 0.
- `MEM_ADDR_CHECK_EN` not defined:
  - The index wraps modulo DEPTH (low log2(DEPTH) bits are used).
  - `addr_err` is tied to 0.

## Test plan
- Reset, then an ALU instruction (`mem_r_en`=`mem_w_en`=0, `alu_res`=32'h5): `ready`=1 every cycle, `alu_res_out`=32'h5, `mem_result`=0.
- STR to `alu_res`=1028 with `val_rm`=32'hDEADBEEF, WAIT_CYCLES=4: `freeze` high for exactly 5 cycles, `ready` high in the 6th. A following LDR from 1028 returns 32'hDEADBEEF in its DONE cycle, after another 5 freeze cycles.
- Back-to-back STR to 1032 (value 7) then LDR from 1032: no idle gap between the two DONE→IDLE sequences; `mem_result`=7.
- `rst` pulsed in the 3rd BUSY cycle of an STR of 32'h1234 to 1040: FSM returns to IDLE, `freeze`=0, and a later LDR from 1040 does not return 32'h1234.
- `mem_r_en`=`mem_w_en`=1 at 1044 with `val_rm`=9: the store executes; `mem_result`=0 in DONE; a subsequent LDR from 1044 returns 9.
- With `MEM_ADDR_CHECK_EN`, DEPTH=64, STR 32'hFF to 1024+256: `addr_err`=1 in DONE and word 0 is unchanged. Without the macro, the same store writes word 0 and `addr_err` stays 0.
